// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the two writeback sources, the arbiter and the register bank.
// The master modport drives the requests and hold; the slave (arbiter) drives grants and the bank side.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic                   hold;
  logic                   req0;
  logic [ADDR_W-1:0]      addr0;
  logic [DATA_W-1:0]      data0;
  logic                   gnt0;
  logic                   req1;
  logic [ADDR_W-1:0]      addr1;
  logic [DATA_W-1:0]      data1;
  logic                   gnt1;
  logic                   RegWrite;
  logic [ADDR_W-1:0]      EscReg;
  logic [DATA_W-1:0]      WriteData;
  logic [(2**ADDR_W)-1:0] busy;
  logic [7:0]             wr_count;

  modport master (
    output hold, req0, addr0, data0, req1, addr1, data1,
    input  gnt0, gnt1, RegWrite, EscReg, WriteData, busy, wr_count
  );

  modport slave (
    input  hold, req0, addr0, data0, req1, addr1, data1,
    output gnt0, gnt1, RegWrite, EscReg, WriteData, busy, wr_count
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register bank write port; grants are combinational, bank write is registered (1 cycle).
// Backpressure: requesters hold req until gnt; hold=1 blocks all grants while the output stage still drains.
module regfile_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  regfile_write_arbiter_if.slave  bus
);
  localparam int NREG = 2**ADDR_W;

  logic              r_ptr;
  logic              r_we;
  logic [ADDR_W-1:0] r_esc;
  logic [DATA_W-1:0] r_wd;
  logic [7:0]        r_cnt;

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_any;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [NREG-1:0]   w_busy;

  // Grants are masked during reset so no transfer can be claimed while state is being cleared.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!reset && !bus.hold) begin
      if (bus.req0 && (!bus.req1 || !r_ptr))
        w_gnt0 = 1'b1;
      else if (bus.req1)
        w_gnt1 = 1'b1;
    end
    w_any  = w_gnt0 | w_gnt1;
    w_addr = w_gnt1 ? bus.addr1 : bus.addr0;
    w_data = w_gnt1 ? bus.data1 : bus.data0;
  end

  always_comb begin
    w_busy = '0;
    if (bus.req0)
      w_busy[bus.addr0] = 1'b1;
    if (bus.req1)
      w_busy[bus.addr1] = 1'b1;
    if (r_we)
      w_busy[r_esc] = 1'b1;
    w_busy[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr <= 1'b0;
      r_we  <= 1'b0;
      r_esc <= '0;
      r_wd  <= '0;
      r_cnt <= 8'd0;
    end else begin
      if (w_any) begin
        // Pointer moves to the loser so continuous contention alternates.
        r_ptr <= w_gnt0;
        r_esc <= w_addr;
        r_wd  <= w_data;
        r_we  <= (w_addr != '0);
      end else begin
        r_we  <= 1'b0;
      end
      if (r_we)
        r_cnt <= r_cnt + 8'd1;
    end
  end

  assign bus.gnt0      = w_gnt0;
  assign bus.gnt1      = w_gnt1;
  assign bus.RegWrite  = r_we;
  assign bus.EscReg    = r_esc;
  assign bus.WriteData = r_wd;
  assign bus.busy      = w_busy;
  assign bus.wr_count  = r_cnt;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed vector table plus hand sequences for async reset and wr_count wrap.
module tb_regfile_write_arbiter;
  logic clock;
  logic reset;
  int   errors;
  int   checks;

  regfile_write_arbiter_if #(.DATA_W(8), .ADDR_W(3)) bif ();

  regfile_write_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic       hold;
    logic       r0;
    logic [2:0] a0;
    logic [7:0] d0;
    logic       r1;
    logic [2:0] a1;
    logic [7:0] d1;
    logic       eg0;
    logic       eg1;
    logic       erw;
    logic [2:0] eesc;
    logic [7:0] ewd;
    logic [7:0] ebusy;
    logic [7:0] ecnt;
  } vec_t;

  vec_t vt[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic h, input logic r0, input logic [2:0] a0, input logic [7:0] d0,
                       input logic r1, input logic [2:0] a1, input logic [7:0] d1);
    bif.hold  = h;
    bif.req0  = r0;
    bif.addr0 = a0;
    bif.data0 = d0;
    bif.req1  = r1;
    bif.addr1 = a1;
    bif.data1 = d1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    //           hold r0 a0    d0     r1 a1    d1     g0 g1 rw esc   wd     busy   cnt
    vt[0]  = '{1'b0,1'b1,3'd4,8'h1B,1'b0,3'd0,8'h00,1'b1,1'b0,1'b0,3'd0,8'h00,8'h10,8'd0};
    vt[1]  = '{1'b0,1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b0,1'b0,1'b1,3'd4,8'h1B,8'h10,8'd0};
    vt[2]  = '{1'b0,1'b1,3'd2,8'h11,1'b1,3'd3,8'h22,1'b0,1'b1,1'b0,3'd4,8'h1B,8'h0C,8'd1};
    vt[3]  = '{1'b0,1'b1,3'd2,8'h11,1'b1,3'd3,8'h22,1'b1,1'b0,1'b1,3'd3,8'h22,8'h0C,8'd1};
    vt[4]  = '{1'b0,1'b1,3'd2,8'h11,1'b1,3'd3,8'h22,1'b0,1'b1,1'b1,3'd2,8'h11,8'h0C,8'd2};
    vt[5]  = '{1'b0,1'b1,3'd2,8'h11,1'b1,3'd3,8'h22,1'b1,1'b0,1'b1,3'd3,8'h22,8'h0C,8'd3};
    vt[6]  = '{1'b0,1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b0,1'b0,1'b1,3'd2,8'h11,8'h04,8'd4};
    vt[7]  = '{1'b0,1'b0,3'd0,8'h00,1'b1,3'd0,8'hFF,1'b0,1'b1,1'b0,3'd2,8'h11,8'h00,8'd5};
    vt[8]  = '{1'b0,1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b0,1'b0,1'b0,3'd0,8'hFF,8'h00,8'd5};
    vt[9]  = '{1'b1,1'b1,3'd5,8'h33,1'b1,3'd7,8'h44,1'b0,1'b0,1'b0,3'd0,8'hFF,8'hA0,8'd5};
    vt[10] = '{1'b1,1'b1,3'd5,8'h33,1'b1,3'd7,8'h44,1'b0,1'b0,1'b0,3'd0,8'hFF,8'hA0,8'd5};
    vt[11] = '{1'b1,1'b1,3'd5,8'h33,1'b1,3'd7,8'h44,1'b0,1'b0,1'b0,3'd0,8'hFF,8'hA0,8'd5};
    vt[12] = '{1'b0,1'b1,3'd5,8'h33,1'b1,3'd7,8'h44,1'b1,1'b0,1'b0,3'd0,8'hFF,8'hA0,8'd5};
    vt[13] = '{1'b1,1'b0,3'd0,8'h00,1'b1,3'd7,8'h44,1'b0,1'b0,1'b1,3'd5,8'h33,8'hA0,8'd5};
    vt[14] = '{1'b0,1'b0,3'd0,8'h00,1'b1,3'd7,8'h44,1'b0,1'b1,1'b0,3'd5,8'h33,8'h80,8'd6};
    vt[15] = '{1'b0,1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b0,1'b0,1'b1,3'd7,8'h44,8'h80,8'd6};
    vt[16] = '{1'b0,1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b0,1'b0,1'b0,3'd7,8'h44,8'h00,8'd7};
    vt[17] = '{1'b0,1'b1,3'd1,8'h01,1'b0,3'd0,8'h00,1'b1,1'b0,1'b0,3'd7,8'h44,8'h02,8'd7};
    vt[18] = '{1'b0,1'b1,3'd6,8'hAA,1'b1,3'd6,8'h55,1'b0,1'b1,1'b1,3'd1,8'h01,8'h42,8'd7};
    vt[19] = '{1'b0,1'b1,3'd6,8'hAA,1'b0,3'd0,8'h00,1'b1,1'b0,1'b1,3'd6,8'h55,8'h40,8'd8};
    vt[20] = '{1'b0,1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b0,1'b0,1'b1,3'd6,8'hAA,8'h40,8'd9};
    vt[21] = '{1'b0,1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b0,1'b0,1'b0,3'd6,8'hAA,8'h00,8'd10};

    // Reset state, with a request present to show grants are suppressed.
    reset = 1'b1;
    drive(1'b0, 1'b1, 3'd4, 8'h1B, 1'b0, 3'd0, 8'h00);
    #12;
    check("rst_gnt0", {31'd0, bif.gnt0}, 32'd0);
    check("rst_regwrite", {31'd0, bif.RegWrite}, 32'd0);
    check("rst_escreg", {29'd0, bif.EscReg}, 32'd0);
    check("rst_writedata", {24'd0, bif.WriteData}, 32'd0);
    check("rst_wr_count", {24'd0, bif.wr_count}, 32'd0);
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    @(posedge clock);
    #1 reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      @(posedge clock);
      #1;
      drive(vt[i].hold, vt[i].r0, vt[i].a0, vt[i].d0, vt[i].r1, vt[i].a1, vt[i].d1);
      #1;
      check($sformatf("v%0d_gnt0", i), {31'd0, bif.gnt0}, {31'd0, vt[i].eg0});
      check($sformatf("v%0d_gnt1", i), {31'd0, bif.gnt1}, {31'd0, vt[i].eg1});
      check($sformatf("v%0d_regwrite", i), {31'd0, bif.RegWrite}, {31'd0, vt[i].erw});
      check($sformatf("v%0d_escreg", i), {29'd0, bif.EscReg}, {29'd0, vt[i].eesc});
      check($sformatf("v%0d_writedata", i), {24'd0, bif.WriteData}, {24'd0, vt[i].ewd});
      check($sformatf("v%0d_busy", i), {24'd0, bif.busy}, {24'd0, vt[i].ebusy});
      check($sformatf("v%0d_wr_count", i), {24'd0, bif.wr_count}, {24'd0, vt[i].ecnt});
    end

    // Reset one cycle after a grant to register 5: the staged write must vanish.
    @(posedge clock);
    #1 drive(1'b0, 1'b1, 3'd5, 8'h5A, 1'b0, 3'd0, 8'h00);
    #1 check("rs_gnt0", {31'd0, bif.gnt0}, 32'd1);
    @(posedge clock);
    #1 check("rs_staged_rw", {31'd0, bif.RegWrite}, 32'd1);
    check("rs_staged_esc", {29'd0, bif.EscReg}, 32'd5);
    reset = 1'b1;
    #1;
    check("rs_async_rw", {31'd0, bif.RegWrite}, 32'd0);
    check("rs_async_esc", {29'd0, bif.EscReg}, 32'd0);
    check("rs_async_cnt", {24'd0, bif.wr_count}, 32'd0);
    check("rs_async_gnt0", {31'd0, bif.gnt0}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    drive(1'b0, 1'b1, 3'd5, 8'h5A, 1'b1, 3'd3, 8'h3C);
    #1;
    check("rs_post_cnt", {24'd0, bif.wr_count}, 32'd0);
    check("rs_post_rw", {31'd0, bif.RegWrite}, 32'd0);
    check("rs_ptr_gnt0", {31'd0, bif.gnt0}, 32'd1);
    check("rs_ptr_gnt1", {31'd0, bif.gnt1}, 32'd0);
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    @(posedge clock);
    #1 check("rs_idle_cnt", {24'd0, bif.wr_count}, 32'd0);

    // wr_count wrap: 256 back-to-back writes to register 1.
    drive(1'b0, 1'b1, 3'd1, 8'h77, 1'b0, 3'd0, 8'h00);
    repeat (256) @(posedge clock);
    #1 drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    check("wrap_cnt255", {24'd0, bif.wr_count}, 32'd255);
    check("wrap_rw", {31'd0, bif.RegWrite}, 32'd1);
    @(posedge clock);
    #1 check("wrap_cnt0", {24'd0, bif.wr_count}, 32'd0);
    check("wrap_rw_off", {31'd0, bif.RegWrite}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
